// File: rtl/chunked_rc_adder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | chunked_rc_adder_if : request/result bundle of chunked_rc_adder  rev 1.0 |
// +--------------------------------------------------------------------+
interface chunked_rc_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C_out;
  logic             ovf;

  modport master (
    output start, sub, A, B, C_in,
    input  busy, done, Sum, C_out, ovf
  );

  modport slave (
    input  start, sub, A, B, C_in,
    output busy, done, Sum, C_out, ovf
  );
endinterface
`default_nettype wire

// File: rtl/chunked_rc_adder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | chunked_rc_adder : multi-cycle add/sub, CHUNK bits per clock  rev 1.0 |
// +--------------------------------------------------------------------+
module chunked_rc_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  chunked_rc_adder_if.slave  bus
);
  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] full_nxt;
  logic [CHUNK-1:0] a_chk;
  logic [CHUNK-1:0] b_chk;
  logic [CHUNK-1:0] s_chk;
  logic [CHUNK:0]   c;
  logic             ready;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_c;
  logic             done_c;

  assign ready  = (state == S_IDLE) || (state == S_DONE);
  assign accept = ready && bus.start;
  assign last   = (cnt == CNT_W'(NCH - 1));

  assign a_chk = a_reg[int'(cnt)*CHUNK +: CHUNK];
  assign b_chk = b_reg[int'(cnt)*CHUNK +: CHUNK];

  // Only a CHUNK-bit carry chain is combinational; the carry between chunks is registered.
  assign c[0] = carry;
  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s_chk[i] = a_chk[i] ^ b_chk[i] ^ c[i];
      assign c[i+1]   = (a_chk[i] & b_chk[i]) | (c[i] & (a_chk[i] ^ b_chk[i]));
    end
  endgenerate

  always_comb begin
    full_nxt = partial;
    full_nxt[int'(cnt)*CHUNK +: CHUNK] = s_chk;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (last)   state_nxt = S_DONE;
      S_DONE:  state_nxt = accept ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      S_RUN:   busy_c = 1'b1;
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      partial <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_reg <= bus.A;
      b_reg <= bus.sub ? ~bus.B : bus.B;
      carry <= bus.sub ? 1'b1 : bus.C_in;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      partial <= full_nxt;
      carry   <= c[CHUNK];
      cnt     <= last ? '0 : cnt + 1'b1;
      if (last) begin
        // At the last chunk the local MSB is the word MSB, so ovf comes from this chain.
        sum_r  <= full_nxt;
        cout_r <= c[CHUNK];
        ovf_r  <= c[CHUNK] ^ c[CHUNK-1];
      end
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.Sum   = sum_r;
  assign bus.C_out = cout_r;
  assign bus.ovf   = ovf_r;
endmodule
`default_nettype wire

// File: tb/tb_chunked_rc_adder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_chunked_rc_adder : scoreboard bench, CHUNK = 4 / 1 / 16    rev 1.0 |
// +--------------------------------------------------------------------+
module tb_chunked_rc_adder;
  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ov;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub, C_in, sweep;
  logic [15:0] A, B;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        q4[$];
  exp_t        q1[$];
  exp_t        q16[$];

  chunked_rc_adder_if #(.WIDTH(16)) bus4  ();
  chunked_rc_adder_if #(.WIDTH(16)) bus1  ();
  chunked_rc_adder_if #(.WIDTH(16)) bus16 ();

  assign bus4.start  = start;
  assign bus1.start  = start & sweep;
  assign bus16.start = start & sweep;
  assign {bus4.sub, bus1.sub, bus16.sub}    = {3{sub}};
  assign {bus4.C_in, bus1.C_in, bus16.C_in} = {3{C_in}};
  assign bus4.A = A;  assign bus1.A = A;  assign bus16.A = A;
  assign bus4.B = B;  assign bus1.B = B;  assign bus16.B = B;

  chunked_rc_adder #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  chunked_rc_adder #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  chunked_rc_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic ci);
    logic [15:0] bb;
    logic [16:0] t;
    exp_t        r;
    bb    = s ? ~b : b;
    t     = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : ci)};
    r.sum = t[15:0];
    r.co  = t[16];
    r.ov  = (a[15] == bb[15]) && (t[15] != a[15]);
    r.due = 0;
    return r;
  endfunction

  task automatic score(input string nm, input exp_t e, input logic [15:0] s,
                       input logic co, input logic ov, input logic bsy);
    chk({nm, "_sum"},     32'(s),   32'(e.sum));
    chk({nm, "_cout"},    32'(co),  32'(e.co));
    chk({nm, "_ovf"},     32'(ov),  32'(e.ov));
    chk({nm, "_latency"}, 32'(cyc), 32'(e.due));
    chk({nm, "_busy_at_done"}, 32'(bsy), 32'd0);
  endtask

  always @(negedge clk) if (bus4.done) begin
    if (q4.size() == 0) chk("c4_unexpected_done", 32'(q4.size()), 32'd1);
    else score("c4", q4.pop_front(), bus4.Sum, bus4.C_out, bus4.ovf, bus4.busy);
  end
  always @(negedge clk) if (bus1.done) begin
    if (q1.size() == 0) chk("c1_unexpected_done", 32'(q1.size()), 32'd1);
    else score("c1", q1.pop_front(), bus1.Sum, bus1.C_out, bus1.ovf, bus1.busy);
  end
  always @(negedge clk) if (bus16.done) begin
    if (q16.size() == 0) chk("c16_unexpected_done", 32'(q16.size()), 32'd1);
    else score("c16", q16.pop_front(), bus16.Sum, bus16.C_out, bus16.ovf, bus16.busy);
  end

  // Called at a negedge where start is high and the next posedge accepts it.
  task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic ci);
    exp_t e;
    e = model(a, b, s, ci);
    e.due = cyc + 1 + 4;
    q4.push_back(e);
    if (sweep) begin
      e.due = cyc + 1 + 16;
      q1.push_back(e);
      e.due = cyc + 1 + 1;
      q16.push_back(e);
    end
  endtask

  // Waits for ready, drives one start pulse, then scrambles the inputs.
  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ci, input bit push);
    int guard = 0;
    @(negedge clk);
    while ((bus4.busy || (sweep && (bus1.busy || bus16.busy))) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 32'(guard), 32'd0);
    A = a; B = b; sub = s; C_in = ci; start = 1'b1;
    if (push) push_exp(a, b, s, ci);
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom); C_in = 1'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q4.size() + q1.size() + q16.size()) != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", 32'(q4.size() + q1.size() + q16.size()), 32'd0);
  endtask

  initial begin
    int bc;
    int guard;
    rst_n = 1'b0; start = 1'b0; sweep = 1'b0; sub = 1'b0; C_in = 1'b0;
    A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_sum",  32'(bus4.Sum),   32'd0);
    chk("rst_cout", 32'(bus4.C_out), 32'd0);
    chk("rst_ovf",  32'(bus4.ovf),   32'd0);
    chk("rst_busy", 32'(bus4.busy),  32'd0);
    chk("rst_done", 32'(bus4.done),  32'd0);
    rst_n = 1'b1;

    // Plain add, with busy-duration measurement
    drive(16'hFFFE, 16'h0001, 1'b0, 1'b0, 1);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus4.done) break;
      if (bus4.busy) bc++;
    end
    chk("busy_cycles", 32'(bc), 32'd4);
    drain();

    drive(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1); drain();
    drive(16'h7FFF, 16'h0000, 1'b0, 1'b1, 1); drain();
    drive(16'h0005, 16'h0007, 1'b1, 1'b1, 1); drain();
    drive(16'h0007, 16'h0005, 1'b1, 1'b0, 1); drain();

    // Start while busy must be ignored
    drive(16'h1234, 16'h1111, 1'b0, 1'b0, 1);
    @(negedge clk);
    A = 16'hFFFF; B = 16'h1111; sub = 1'b0; C_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    repeat (6) @(negedge clk);

    // start held high through DONE: back-to-back accept
    @(negedge clk);
    A = 16'h0001; B = 16'h0001; sub = 1'b0; C_in = 1'b0; start = 1'b1;
    push_exp(16'h0001, 16'h0001, 1'b0, 1'b0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus4.done && guard < 20);
    if (guard >= 20) chk("b2b_timeout", 32'(guard), 32'd0);
    push_exp(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset during chunk 2 aborts the operation
    drive(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_sum",  32'(bus4.Sum),   32'd0);
    chk("midrst_cout", 32'(bus4.C_out), 32'd0);
    chk("midrst_busy", 32'(bus4.busy),  32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_done", 32'(bus4.done),  32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    drive(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1); drain();

    // All three chunk sizes against the model
    sweep = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1); drain();
    drive(16'h8000, 16'h0001, 1'b1, 1'b0, 1); drain();
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 1); drain();
    for (int i = 0; i < 25; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
      drain();
    end
    sweep = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/chunked_rc_adder.md
# chunked_rc_adder

- Parametrised, multi-cycle ripple-carry adder/subtractor.
- Adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, holding the inter-chunk carry in a register.
- Trades latency for a short carry chain, so wide adds close timing without a full-width ripple path.
- Sits in the arithmetic datapath; generalises the team's fixed 4-bit combinational ripple-carry adder with width, chunk size, subtract mode, a start/done handshake and a signed-overflow flag.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK, ≥ 2.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. NCH = WIDTH/CHUNK is the number of compute cycles.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on a rising edge while ready.
- sub  input  1  0 = A+B+C_in, 1 = A−B (computed as A + ~B + 1); sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- C_in  input  1  carry in for add; ignored when sub=1.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse: Sum/C_out/ovf are valid.
- Sum  output  WIDTH  result, held until the next result completes.
- C_out  output  1  carry out of the MSB. For sub, 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  two's-complement signed overflow of the result.

## Operation
- States:
  - IDLE: ready.
  - RUN: chunk counter 0..NCH−1.
  - DONE: one cycle, ready.
- "Ready" means IDLE or DONE; start is accepted only when ready.
- On accept:
  - Latch A, and B (or ~B when sub=1).
  - Load the carry register with C_in (add) or 1 (sub).
  - Clear the chunk counter, enter RUN, busy=1.
- RUN, each cycle for chunk i:
  - Compute A[i] + B'[i] + carry with a CHUNK-bit ripple adder.
  - Write the CHUNK-bit result into the internal partial register at bit offset i·CHUNK.
  - Update the carry register.
- At the last chunk (i = NCH−1):
  - Sum ← full partial result (including the final chunk).
  - C_out ← final carry.
  - ovf ← carry into MSB XOR carry out of MSB.
  - Go to DONE.
- DONE: done=1, busy=0. Next state is IDLE, or RUN if start is accepted in this cycle (back-to-back).
- start while busy=1 is ignored; no queueing, and in-flight operands are unaffected.
- Input changes on A/B/sub/C_in after acceptance have no effect.
- Sum/C_out/ovf change only on the completion edge. They never show partial results and hold their value across IDLE and subsequent RUN cycles.
- Arithmetic is modulo 2^WIDTH; the carry beyond WIDTH appears only on C_out.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, Sum=0, C_out=0, ovf=0; counter, carry and partial registers cleared.
- Reset during RUN aborts the operation; no done pulse follows.
- rst_n deassertion is synchronised externally; the first accept is possible on the first edge with rst_n high.
- start accepted at edge k:
  - busy rises after edge k.
  - Results and done appear after edge k+NCH.
  - busy falls after edge k+NCH, so busy is high for exactly NCH cycles.
  - done is high for exactly one cycle.
- CHUNK=WIDTH: NCH=1, so done occurs one cycle after start.
- Throughput: one operation per NCH+... cycles. With start held high in DONE, a new operation is accepted every NCH+1 edges.
- done and busy are never high together.

## Test plan
(WIDTH=16, CHUNK=4 unless noted)
- Add, no carry: A=0xFFFE, B=0x0001, C_in=0, sub=0 -> Sum=0xFFFF, C_out=0, ovf=0; done exactly 4 cycles after the start edge, busy high 4 cycles.
- Carry and signed overflow: A=0x8000, B=0xFFFF -> Sum=0x7FFF, C_out=1, ovf=1. Separately, A=0x7FFF, B=0x0000, C_in=1 -> Sum=0x8000, C_out=0, ovf=1.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1, C_in=1 -> Sum=0xFFFE, C_out=0, ovf=0. Separately, A=0x0007, B=0x0005 -> Sum=0x0002, C_out=1.
- Handshake, part 1: pulse start with A=0x1234, B=0x1111; pulse start again with A=0xFFFF two cycles later -> second start ignored, Sum=0x2345.
- Handshake, part 2: hold start high through DONE with A=0x0001, B=0x0001 -> second op accepted, next done 5 cycles after the first, Sum=0x0002.
- Reset mid-op: assert rst_n low during chunk 2 -> outputs 0 immediately, no done pulse. After release, A=0x0F0F, B=0xF0F0 -> Sum=0xFFFF, C_out=0.
- Parameter sweep: CHUNK ∈ {1, 4, 16} with WIDTH=16, random operands vs. reference model -> identical results; latency = 16, 4, 1 respectively.
